// File: rtl/axi_lite_apb_pkg.sv
// Shared constants for the AXI-lite to APB bridge: FSM state codes, response codes,
// transfer kind and the ACCESS timeout length.
package axi_lite_apb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic {
        XFER_WRITE = 1'b0,
        XFER_READ  = 1'b1
    } xfer_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/axi_lite_apb_arb.sv
// Two-request round-robin between AXI-lite write and read, with a last-grant register.
module axi_lite_apb_arb
    import axi_lite_apb_pkg::*;
(
    input  logic axi_clk,
    input  logic sys_reset,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr,
    output logic gnt_rd
);

    xfer_e last_kind;

    // Only contested grants move the pointer, so an uncontested grant never
    // changes who wins the next tie.
    always_comb begin
        gnt_wr = req_wr && (!req_rd || (last_kind == XFER_READ));
        gnt_rd = req_rd && (!req_wr || (last_kind == XFER_WRITE));
    end

    always_ff @(posedge axi_clk) begin
        if (sys_reset) begin
            last_kind <= XFER_READ;
        end else if (req_wr && req_rd) begin
            last_kind <= gnt_wr ? XFER_WRITE : XFER_READ;
        end
    end

endmodule

// File: rtl/axi_lite_to_apb_bridge.sv
// AXI-lite target to APB4 initiator, one transfer in flight (IDLE/SETUP/ACCESS/RESP).
// Define AXI_LITE_TO_APB_TIMEOUT_EN to bound ACCESS to TIMEOUT_CYCLES and answer SLVERR.
`ifndef AW_AXI
`define AW_AXI 32
`endif
`ifndef DW_AXI
`define DW_AXI 64
`endif
`ifndef AW_APB
`define AW_APB 16
`endif
`ifndef DW_APB
`define DW_APB 64
`endif

module axi_lite_to_apb_bridge
    import axi_lite_apb_pkg::*;
#(
    parameter int AW_AXI = `AW_AXI,
    parameter int DW_AXI = `DW_AXI,
    parameter int AW_APB = `AW_APB,
    parameter int DW_APB = `DW_APB
) (
    input  logic                  axi_clk,
    input  logic                  sys_reset,

    input  logic [AW_AXI-1:0]     s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DW_AXI-1:0]     s_axi_wdata,
    input  logic [DW_AXI/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [AW_AXI-1:0]     s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DW_AXI-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,

    output logic [AW_APB-1:0]     m_apb_paddr,
    output logic [2:0]            m_apb_pprot,
    output logic                  m_apb_psel,
    output logic                  m_apb_penable,
    output logic                  m_apb_pwrite,
    output logic [DW_APB-1:0]     m_apb_pwdata,
    output logic [DW_APB/8-1:0]   m_apb_pstrb,
    input  logic                  m_apb_pready,
    input  logic [DW_APB-1:0]     m_apb_prdata,
    input  logic                  m_apb_pslverr
);

    logic [1:0] state;
    logic       idle;
    logic       wr_req;
    logic       rd_req;
    logic       gnt_wr;
    logic       gnt_rd;
    logic       access_done;
    logic       tmo_hit;
    logic [1:0] done_resp;

    // Readies are combinational so the accept cycle is the cycle the request is seen.
    assign idle   = (state == ST_IDLE) && !sys_reset;
    assign wr_req = idle && s_axi_awvalid && s_axi_wvalid;
    assign rd_req = idle && s_axi_arvalid;

    axi_lite_apb_arb u_arb (
        .axi_clk   (axi_clk),
        .sys_reset (sys_reset),
        .req_wr    (wr_req),
        .req_rd    (rd_req),
        .gnt_wr    (gnt_wr),
        .gnt_rd    (gnt_rd)
    );

    assign s_axi_awready = gnt_wr;
    assign s_axi_wready  = gnt_wr;
    assign s_axi_arready = gnt_rd;

`ifdef AXI_LITE_TO_APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == '0);

    always_ff @(posedge axi_clk) begin
        if (sys_reset) begin
            tmo_cnt <= '0;
        end else if (state == ST_SETUP) begin
            tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
        end else if ((state == ST_ACCESS) && !m_apb_pready && !tmo_hit) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // A timeout completes ACCESS without pready and is reported as SLVERR.
    assign access_done = m_apb_pready || tmo_hit;
    assign done_resp   = (!m_apb_pready || m_apb_pslverr) ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge axi_clk) begin
        if (sys_reset) begin
            state         <= ST_IDLE;
            m_apb_paddr   <= '0;
            m_apb_pprot   <= '0;
            m_apb_psel    <= 1'b0;
            m_apb_penable <= 1'b0;
            m_apb_pwrite  <= 1'b0;
            m_apb_pwdata  <= '0;
            m_apb_pstrb   <= '0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_wr) begin
                        state        <= ST_SETUP;
                        m_apb_psel   <= 1'b1;
                        m_apb_pwrite <= 1'b1;
                        m_apb_paddr  <= s_axi_awaddr[AW_APB-1:0];
                        m_apb_pprot  <= s_axi_awprot;
                        m_apb_pwdata <= s_axi_wdata;
                        m_apb_pstrb  <= s_axi_wstrb;
                    end else if (gnt_rd) begin
                        state        <= ST_SETUP;
                        m_apb_psel   <= 1'b1;
                        m_apb_pwrite <= 1'b0;
                        m_apb_paddr  <= s_axi_araddr[AW_APB-1:0];
                        m_apb_pprot  <= s_axi_arprot;
                        m_apb_pwdata <= '0;
                        m_apb_pstrb  <= '0;
                    end
                end
                ST_SETUP: begin
                    state         <= ST_ACCESS;
                    m_apb_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    if (access_done) begin
                        state         <= ST_RESP;
                        m_apb_psel    <= 1'b0;
                        m_apb_penable <= 1'b0;
                        if (m_apb_pwrite) begin
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= done_resp;
                        end else begin
                            s_axi_rvalid <= 1'b1;
                            s_axi_rresp  <= done_resp;
                            s_axi_rdata  <= m_apb_pready ? m_apb_prdata : '0;
                        end
                    end
                end
                default: begin
                    if ((s_axi_bvalid && s_axi_bready) || (s_axi_rvalid && s_axi_rready)) begin
                        state        <= ST_IDLE;
                        s_axi_bvalid <= 1'b0;
                        s_axi_rvalid <= 1'b0;
                    end
                end
            endcase
        end
    end

    if (AW_AXI > AW_APB) begin : g_addr_trunc
        logic unused_addr_bits;
        assign unused_addr_bits = ^{s_axi_awaddr[AW_AXI-1:AW_APB], s_axi_araddr[AW_AXI-1:AW_APB]};
    end

endmodule

// File: tb/tb_axi_lite_to_apb_bridge.sv
// Self-checking bench for axi_lite_to_apb_bridge: AXI-lite master tasks, an APB slave
// model and queues of expected APB transfers and AXI responses.
module tb_axi_lite_to_apb_bridge;

    localparam int AW_AXI = 32;
    localparam int DW_AXI = 64;
    localparam int AW_APB = 16;
    localparam int DW_APB = 64;
    localparam int SW     = DW_AXI / 8;

    logic              axi_clk = 1'b0;
    logic              sys_reset;
    logic [AW_AXI-1:0] s_axi_awaddr;
    logic [2:0]        s_axi_awprot;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [DW_AXI-1:0] s_axi_wdata;
    logic [SW-1:0]     s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [AW_AXI-1:0] s_axi_araddr;
    logic [2:0]        s_axi_arprot;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [DW_AXI-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic [AW_APB-1:0] m_apb_paddr;
    logic [2:0]        m_apb_pprot;
    logic              m_apb_psel;
    logic              m_apb_penable;
    logic              m_apb_pwrite;
    logic [DW_APB-1:0] m_apb_pwdata;
    logic [SW-1:0]     m_apb_pstrb;
    logic              m_apb_pready;
    logic [DW_APB-1:0] m_apb_prdata;
    logic              m_apb_pslverr;

    always #5 axi_clk = ~axi_clk;

    axi_lite_to_apb_bridge #(
        .AW_AXI(AW_AXI), .DW_AXI(DW_AXI), .AW_APB(AW_APB), .DW_APB(DW_APB)
    ) dut (
        .axi_clk       (axi_clk),
        .sys_reset     (sys_reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .m_apb_paddr   (m_apb_paddr),
        .m_apb_pprot   (m_apb_pprot),
        .m_apb_psel    (m_apb_psel),
        .m_apb_penable (m_apb_penable),
        .m_apb_pwrite  (m_apb_pwrite),
        .m_apb_pwdata  (m_apb_pwdata),
        .m_apb_pstrb   (m_apb_pstrb),
        .m_apb_pready  (m_apb_pready),
        .m_apb_prdata  (m_apb_prdata),
        .m_apb_pslverr (m_apb_pslverr)
    );

    typedef struct {
        logic              wr;
        logic [AW_APB-1:0] addr;
        logic [2:0]        prot;
        logic [DW_APB-1:0] wdata;
        logic [SW-1:0]     strb;
    } apb_exp_t;

    typedef struct {
        logic              wr;
        logic [1:0]        resp;
        logic [DW_AXI-1:0] rdata;
    } rsp_exp_t;

    apb_exp_t apb_q[$];
    rsp_exp_t rsp_q[$];

    int checks   = 0;
    int failures = 0;

    int                slv_wait     = 0;
    logic              slv_err      = 1'b0;
    logic              slv_hang     = 1'b0;
    logic [DW_APB-1:0] slv_rdata    = '0;
    int                acc_cnt      = 0;
    int                last_acc_len = 0;

    // APB slave model: answers after slv_wait extra ACCESS cycles, checks each
    // transfer against the expected queue on its first ACCESS cycle.
    initial begin : apb_slave
        apb_exp_t e;
        m_apb_pready  = 1'b0;
        m_apb_prdata  = '0;
        m_apb_pslverr = 1'b0;
        forever begin
            @(posedge axi_clk);
            #1;
            if (m_apb_psel && m_apb_penable) begin
                if (acc_cnt == 0) begin
                    checks++;
                    if (apb_q.size() == 0) begin
                        failures++;
                        $display("FAIL apb_unexpected_transfer paddr=%h pwrite=%b", m_apb_paddr, m_apb_pwrite);
                    end else begin
                        e = apb_q.pop_front();
                        if ({m_apb_pwrite, m_apb_paddr, m_apb_pprot, m_apb_pstrb} !== {e.wr, e.addr, e.prot, e.strb} ||
                            (e.wr && (m_apb_pwdata !== e.wdata))) begin
                            failures++;
                            $display("FAIL apb_fields got w=%b a=%h p=%h s=%h d=%h exp w=%b a=%h p=%h s=%h d=%h",
                                     m_apb_pwrite, m_apb_paddr, m_apb_pprot, m_apb_pstrb, m_apb_pwdata,
                                     e.wr, e.addr, e.prot, e.strb, e.wdata);
                        end
                    end
                end
                acc_cnt++;
                if (!slv_hang && (acc_cnt > slv_wait)) begin
                    m_apb_pready  = 1'b1;
                    m_apb_prdata  = slv_rdata;
                    m_apb_pslverr = slv_err;
                end else begin
                    m_apb_pready  = 1'b0;
                    m_apb_prdata  = 64'hBAD0_BAD0_BAD0_BAD0;
                    m_apb_pslverr = 1'b0;
                end
            end else begin
                if (acc_cnt > 0) last_acc_len = acc_cnt;
                acc_cnt       = 0;
                m_apb_pready  = 1'b0;
                m_apb_prdata  = 64'hBAD0_BAD0_BAD0_BAD0;
                m_apb_pslverr = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic wait_wr_accept();
        int n = 0;
        #1;
        while (!(s_axi_awready && s_axi_wready) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!(s_axi_awready && s_axi_wready)) begin
            failures++;
            $display("FAIL wr_accept_timeout awready=%b wready=%b", s_axi_awready, s_axi_wready);
        end
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
    endtask

    task automatic wait_rd_accept();
        int n = 0;
        #1;
        while (!s_axi_arready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!s_axi_arready) begin
            failures++;
            $display("FAIL rd_accept_timeout arready=%b", s_axi_arready);
        end
        tick();
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_resp(input int hold);
        int                n = 0;
        rsp_exp_t          e;
        logic [1:0]        got;
        logic [DW_AXI-1:0] rd0;
        while (!(s_axi_bvalid || s_axi_rvalid) && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (!(s_axi_bvalid || s_axi_rvalid)) begin
            failures++;
            $display("FAIL resp_timeout bvalid=%b rvalid=%b", s_axi_bvalid, s_axi_rvalid);
            return;
        end
        checks++;
        if (rsp_q.size() == 0) begin
            failures++;
            $display("FAIL resp_unexpected bvalid=%b rvalid=%b", s_axi_bvalid, s_axi_rvalid);
            return;
        end
        e = rsp_q.pop_front();
        checks++;
        if ({s_axi_bvalid, s_axi_rvalid} !== (e.wr ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL resp_kind got b/r=%b%b exp wr=%b", s_axi_bvalid, s_axi_rvalid, e.wr);
        end
        got = e.wr ? s_axi_bresp : s_axi_rresp;
        checks++;
        if (got !== e.resp) begin
            failures++;
            $display("FAIL resp_code got %b exp %b", got, e.resp);
        end
        if (!e.wr) begin
            checks++;
            if (s_axi_rdata !== e.rdata) begin
                failures++;
                $display("FAIL rdata got %h exp %h", s_axi_rdata, e.rdata);
            end
        end
        rd0 = s_axi_rdata;
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if ((e.wr ? !s_axi_bvalid : !s_axi_rvalid) || ((e.wr ? s_axi_bresp : s_axi_rresp) !== e.resp) ||
                (!e.wr && (s_axi_rdata !== rd0)) || s_axi_arready || s_axi_awready) begin
                failures++;
                $display("FAIL resp_hold cycle=%0d b=%b r=%b bresp=%b rresp=%b arready=%b awready=%b",
                         i, s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_arready, s_axi_awready);
            end
        end
        s_axi_bready = e.wr;
        s_axi_rready = !e.wr;
        #1;
        checks++;
        if (s_axi_arready || s_axi_awready || s_axi_wready) begin
            failures++;
            $display("FAIL accept_during_resp arready=%b awready=%b wready=%b",
                     s_axi_arready, s_axi_awready, s_axi_wready);
        end
        tick();
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        checks++;
        if (s_axi_bvalid || s_axi_rvalid) begin
            failures++;
            $display("FAIL resp_not_cleared bvalid=%b rvalid=%b", s_axi_bvalid, s_axi_rvalid);
        end
    endtask

    task automatic test_reset();
        sys_reset     = 1'b1;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_arvalid = 1'b1;
        tick();
        tick();
        checks++;
        if ({m_apb_psel, m_apb_penable, m_apb_pwrite} !== 3'b000) begin
            failures++;
            $display("FAIL reset_apb_ctrl got %b exp 000", {m_apb_psel, m_apb_penable, m_apb_pwrite});
        end
        checks++;
        if ({m_apb_paddr, m_apb_pwdata, m_apb_pstrb, m_apb_pprot} !== '0) begin
            failures++;
            $display("FAIL reset_apb_data paddr=%h pwdata=%h pstrb=%h pprot=%h exp 0",
                     m_apb_paddr, m_apb_pwdata, m_apb_pstrb, m_apb_pprot);
        end
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_readies got %b exp 000", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        checks++;
        if ({s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp} !== 6'b0) begin
            failures++;
            $display("FAIL reset_resp got b=%b r=%b bresp=%b rresp=%b exp 0",
                     s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp);
        end
        checks++;
        if (s_axi_rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata got %h exp 0", s_axi_rdata);
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        sys_reset     = 1'b0;
        tick();
    endtask

    task automatic test_arbitration();
        apb_q.push_back('{1'b1, 16'h0100, 3'b001, 64'hAAAA_0000_0000_0001, 8'h0F});
        rsp_q.push_back('{1'b1, 2'b00, 64'h0});
        apb_q.push_back('{1'b0, 16'h0200, 3'b000, 64'h0, 8'h00});
        rsp_q.push_back('{1'b0, 2'b00, 64'h5555_0000_0000_0002});
        slv_rdata     = 64'h5555_0000_0000_0002;
        s_axi_awaddr  = 32'h0000_0100;
        s_axi_awprot  = 3'b001;
        s_axi_wdata   = 64'hAAAA_0000_0000_0001;
        s_axi_wstrb   = 8'h0F;
        s_axi_araddr  = 32'h0000_0200;
        s_axi_arprot  = 3'b000;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_arvalid = 1'b1;
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b110) begin
            failures++;
            $display("FAIL arb_first_tie got %b exp 110", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        wait_wr_accept();
        wait_resp(0);
        wait_rd_accept();
        wait_resp(0);

        apb_q.push_back('{1'b0, 16'h0300, 3'b100, 64'h0, 8'h00});
        rsp_q.push_back('{1'b0, 2'b00, 64'h6666_0000_0000_0003});
        apb_q.push_back('{1'b1, 16'h0400, 3'b010, 64'hBBBB_0000_0000_0004, 8'hF0});
        rsp_q.push_back('{1'b1, 2'b00, 64'h0});
        slv_rdata     = 64'h6666_0000_0000_0003;
        s_axi_awaddr  = 32'hABCD_0400;
        s_axi_awprot  = 3'b010;
        s_axi_wdata   = 64'hBBBB_0000_0000_0004;
        s_axi_wstrb   = 8'hF0;
        s_axi_araddr  = 32'h1234_0300;
        s_axi_arprot  = 3'b100;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_arvalid = 1'b1;
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b001) begin
            failures++;
            $display("FAIL arb_second_tie got %b exp 001", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        wait_rd_accept();
        wait_resp(0);
        wait_wr_accept();
        wait_resp(0);
    endtask

    task automatic test_single_write();
        slv_wait = 0;
        apb_q.push_back('{1'b1, 16'h0010, 3'b000, 64'h0123_4567_89AB_CDEF, 8'hFF});
        rsp_q.push_back('{1'b1, 2'b00, 64'h0});
        s_axi_awaddr  = 32'h0000_0010;
        s_axi_awprot  = 3'b000;
        s_axi_wdata   = 64'h0123_4567_89AB_CDEF;
        s_axi_wstrb   = 8'hFF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b110) begin
            failures++;
            $display("FAIL wr_accept_n got %b exp 110", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        tick();
        checks++;
        if ({m_apb_psel, m_apb_penable, s_axi_awready, s_axi_wready} !== 4'b1000) begin
            failures++;
            $display("FAIL wr_setup_n1 psel/penable/awready/wready got %b exp 1000",
                     {m_apb_psel, m_apb_penable, s_axi_awready, s_axi_wready});
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        tick();
        checks++;
        if ({m_apb_psel, m_apb_penable, m_apb_pwrite} !== 3'b111 || m_apb_pwdata !== 64'h0123_4567_89AB_CDEF) begin
            failures++;
            $display("FAIL wr_access_n2 ctrl=%b pwdata=%h exp 111 0123456789abcdef",
                     {m_apb_psel, m_apb_penable, m_apb_pwrite}, m_apb_pwdata);
        end
        tick();
        checks++;
        if ({s_axi_bvalid, m_apb_psel, m_apb_penable} !== 3'b100) begin
            failures++;
            $display("FAIL wr_resp_n3 bvalid/psel/penable got %b exp 100",
                     {s_axi_bvalid, m_apb_psel, m_apb_penable});
        end
        wait_resp(0);
    endtask

    task automatic test_read_wait();
        slv_wait  = 3;
        slv_rdata = 64'hDEAD_BEEF_0000_0001;
        apb_q.push_back('{1'b0, 16'h0010, 3'b000, 64'h0, 8'h00});
        rsp_q.push_back('{1'b0, 2'b00, 64'hDEAD_BEEF_0000_0001});
        s_axi_araddr  = 32'h0000_0010;
        s_axi_arprot  = 3'b000;
        s_axi_arvalid = 1'b1;
        wait_rd_accept();
        wait_resp(0);
        checks++;
        if (last_acc_len !== 4) begin
            failures++;
            $display("FAIL rd_penable_len got %0d exp 4", last_acc_len);
        end
        slv_wait = 0;
    endtask

    task automatic test_slverr_hold();
        slv_err   = 1'b1;
        slv_rdata = 64'h1122_3344_5566_7788;
        apb_q.push_back('{1'b1, 16'h0020, 3'b010, 64'hFEED_FACE_0000_0020, 8'h3C});
        rsp_q.push_back('{1'b1, 2'b10, 64'h0});
        apb_q.push_back('{1'b0, 16'h0028, 3'b011, 64'h0, 8'h00});
        rsp_q.push_back('{1'b0, 2'b00, 64'h1122_3344_5566_7788});
        s_axi_awaddr  = 32'h0000_0020;
        s_axi_awprot  = 3'b010;
        s_axi_wdata   = 64'hFEED_FACE_0000_0020;
        s_axi_wstrb   = 8'h3C;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        wait_wr_accept();
        s_axi_araddr  = 32'h0000_0028;
        s_axi_arprot  = 3'b011;
        s_axi_arvalid = 1'b1;
        wait_resp(5);
        slv_err = 1'b0;
        wait_rd_accept();
        wait_resp(0);
    endtask

    task automatic test_reset_in_access();
        int n = 0;
        slv_hang = 1'b1;
        apb_q.push_back('{1'b1, 16'h0030, 3'b000, 64'h0000_0000_0000_0030, 8'hFF});
        s_axi_awaddr  = 32'h0000_0030;
        s_axi_awprot  = 3'b000;
        s_axi_wdata   = 64'h0000_0000_0000_0030;
        s_axi_wstrb   = 8'hFF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        wait_wr_accept();
        while (!(m_apb_psel && m_apb_penable) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!(m_apb_psel && m_apb_penable)) begin
            failures++;
            $display("FAIL rst_access_not_reached psel=%b penable=%b", m_apb_psel, m_apb_penable);
        end
        sys_reset = 1'b1;
        tick();
        checks++;
        if ({m_apb_psel, m_apb_penable, s_axi_bvalid, s_axi_rvalid} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_abort psel/penable/bvalid/rvalid got %b exp 0000",
                     {m_apb_psel, m_apb_penable, s_axi_bvalid, s_axi_rvalid});
        end
        sys_reset = 1'b0;
        slv_hang  = 1'b0;
        tick();
        checks++;
        if ({m_apb_psel, s_axi_bvalid, s_axi_rvalid} !== 3'b000) begin
            failures++;
            $display("FAIL rst_after got psel/bvalid/rvalid %b exp 000", {m_apb_psel, s_axi_bvalid, s_axi_rvalid});
        end
        apb_q.delete();
        rsp_q.delete();
        apb_q.push_back('{1'b1, 16'h0034, 3'b001, 64'h7777_8888_9999_0034, 8'hA5});
        rsp_q.push_back('{1'b1, 2'b00, 64'h0});
        s_axi_awaddr  = 32'h0000_0034;
        s_axi_awprot  = 3'b001;
        s_axi_wdata   = 64'h7777_8888_9999_0034;
        s_axi_wstrb   = 8'hA5;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        wait_wr_accept();
        wait_resp(0);
    endtask

    task automatic test_timeout();
        slv_hang  = 1'b1;
        slv_rdata = 64'hCAFE_0000_0000_0040;
        apb_q.push_back('{1'b0, 16'h0040, 3'b000, 64'h0, 8'h00});
`ifdef AXI_LITE_TO_APB_TIMEOUT_EN
        rsp_q.push_back('{1'b0, 2'b10, 64'h0});
`else
        rsp_q.push_back('{1'b0, 2'b00, 64'hCAFE_0000_0000_0040});
`endif
        s_axi_araddr  = 32'h0000_0040;
        s_axi_arprot  = 3'b000;
        s_axi_arvalid = 1'b1;
        wait_rd_accept();
`ifdef AXI_LITE_TO_APB_TIMEOUT_EN
        wait_resp(0);
        checks++;
        if (last_acc_len !== 256) begin
            failures++;
            $display("FAIL timeout_len got %0d exp 256", last_acc_len);
        end
`else
        repeat (300) tick();
        checks++;
        if ({m_apb_psel, m_apb_penable, s_axi_rvalid} !== 3'b110) begin
            failures++;
            $display("FAIL no_timeout_wait psel/penable/rvalid got %b exp 110",
                     {m_apb_psel, m_apb_penable, s_axi_rvalid});
        end
        slv_hang = 1'b0;
        wait_resp(0);
`endif
        slv_hang = 1'b0;
    endtask

    initial begin : main
        sys_reset     = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_awprot  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arprot  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;

        test_reset();
        test_arbitration();
        test_single_write();
        test_read_wait();
        test_slverr_hold();
        test_reset_in_access();
        test_timeout();

        checks++;
        if (apb_q.size() != 0 || rsp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations apb=%0d rsp=%0d exp 0", apb_q.size(), rsp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
